// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: valid/ready memory request channel with a separate read-response strobe.
//   m_valid/m_addr/m_wdata/m_we : request, held until m_valid && m_ready
//   m_ready                     : request accepted by the memory
//   m_rvalid/m_rdata            : read response, one cycle wide
//   master modport faces the bridge, slave modport faces the memory
interface mem_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    modport master (output m_valid, m_addr, m_wdata, m_we, input m_ready, m_rvalid, m_rdata);
    modport slave (input m_valid, m_addr, m_wdata, m_we, output m_ready, m_rvalid, m_rdata);
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns each memory-touching core state into one bus transaction and stalls the core until it completes.
//   clk, reset          : clock, asynchronous active-high reset
//   cpu_access/we/adr/wdata : access request from the multicycle core
//   cpu_rdata           : registered read data (captured by IR/data registers in DONE)
//   stall               : holds core sequential state while the access is in flight
//   bus_err             : sticky timeout flag, cleared only by reset
//   m                   : memory-side request/response channel
module mem_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_access,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              bus_err,
    mem_bus_bridge_if.master  m
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              m_we_q, m_we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic              timeout_hit;

    assign cnt_inc     = cnt_q + CW'(1);
    // Fires on the edge that would complete the TIMEOUT-th REQ/WAIT cycle.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        bus_err_d   = bus_err_q;
        m_valid_d   = m_valid_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (cpu_access) begin
                m_addr_d  = cpu_adr;
                m_wdata_d = cpu_wdata;
                m_we_d    = cpu_we;
                m_valid_d = 1'b1;
                cnt_d     = '0;
                state_d   = REQ;
            end
            REQ: begin
                cnt_d = cnt_inc;
                // Acceptance takes priority over a coincident timeout.
                if (m.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = m_we_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    m_valid_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    state_d     = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (m.m_rvalid) begin
                    cpu_rdata_d = m.m_rdata;
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    bus_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall     = cpu_access && (state_q != DONE);
    assign cpu_rdata = cpu_rdata_q;
    assign bus_err   = bus_err_q;
    assign m.m_valid = m_valid_q;
    assign m.m_addr  = m_addr_q;
    assign m.m_wdata = m_wdata_q;
    assign m.m_we    = m_we_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed scenario tests for mem_bus_bridge with hand-computed expectations.
module tb_mem_bus_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_access;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        bus_err;
    int          n_cmp = 0;
    int          n_fail = 0;

    mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cpu_access(cpu_access), .cpu_we(cpu_we),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .bus_err(bus_err), .m(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_access = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        tick(); tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", bus.m_valid); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", bus_err); end
        n_cmp++; if ({bus.m_addr, bus.m_wdata, bus.m_we} !== 65'h0) begin n_fail++; $display("FAIL rst_req: got %h %h %0b want 0", bus.m_addr, bus.m_wdata, bus.m_we); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_read();
        cpu_access = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_1000;
        bus.m_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0050_0113;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL zr_stall_idle: got %0b want 1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL zr_stall_req: got %0b want 1", stall); end
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL zr_valid: got %0b want 1", bus.m_valid); end
        n_cmp++; if (bus.m_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL zr_addr: got %h want 00001000", bus.m_addr); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL zr_rvalid_idle: got %h want 0", cpu_rdata); end
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL zr_stall_wait: got %0b want 1", stall); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL zr_valid_drop: got %0b want 0", bus.m_valid); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL zr_rvalid_req: got %h want 0", cpu_rdata); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zr_stall_done: got %0b want 0", stall); end
        n_cmp++; if (cpu_rdata !== 32'h0050_0113) begin n_fail++; $display("FAIL zr_rdata: got %h want 00500113", cpu_rdata); end
        cpu_access = 1'b0; bus.m_rvalid = 1'b0;
        tick();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL zr_idle_valid: got %0b want 0", bus.m_valid); end
    endtask

    task automatic test_write_backpressure();
        cpu_access = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0000_2004; cpu_wdata = 32'hDEAD_BEEF;
        bus.m_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid[%0d]: got %0b want 1", i, bus.m_valid); end
            n_cmp++; if ({bus.m_addr, bus.m_wdata, bus.m_we} !== {32'h0000_2004, 32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL wb_req[%0d]: got %h %h %0b want 00002004 deadbeef 1", i, bus.m_addr, bus.m_wdata, bus.m_we); end
            n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wb_stall[%0d]: got %0b want 1", i, stall); end
            if (i == 5) bus.m_ready = 1'b1;
            tick();
        end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wb_stall_done: got %0b want 0", stall); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL wb_valid_done: got %0b want 0", bus.m_valid); end
        n_cmp++; if (cpu_rdata !== 32'h0050_0113) begin n_fail++; $display("FAIL wb_rdata: got %h want 00500113", cpu_rdata); end
        cpu_access = 1'b0;
        tick();
    endtask

    task automatic test_input_churn();
        cpu_access = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_1000; bus.m_ready = 1'b0;
        tick();
        cpu_adr = 32'h0000_5000; cpu_we = 1'b1; cpu_wdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({bus.m_addr, bus.m_we} !== {32'h0000_1000, 1'b0}) begin n_fail++; $display("FAIL churn_req[%0d]: got %h %0b want 00001000 0", i, bus.m_addr, bus.m_we); end
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1111_2222;
        tick();
        n_cmp++; if (cpu_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL churn_rdata: got %h want 11112222", cpu_rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL churn_done: got %0b want 0", stall); end
        cpu_access = 1'b0; bus.m_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_access = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0000_3000; cpu_wdata = 32'hA5A5_A5A5;
        bus.m_ready = 1'b1; bus.m_rvalid = 1'b0;
        tick();
        n_cmp++; if ({bus.m_valid, bus.m_addr, bus.m_we} !== {1'b1, 32'h0000_3000, 1'b1}) begin n_fail++; $display("FAIL b2b_wr_req: got %0b %h %0b want 1 00003000 1", bus.m_valid, bus.m_addr, bus.m_we); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_done: got %0b want 0", stall); end
        cpu_we = 1'b0; cpu_adr = 32'h0000_0008;
        tick();
        n_cmp++; if ({bus.m_valid, stall} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap: got valid=%0b stall=%0b want valid=0 stall=1", bus.m_valid, stall); end
        tick();
        n_cmp++; if ({bus.m_valid, bus.m_addr, bus.m_we} !== {1'b1, 32'h0000_0008, 1'b0}) begin n_fail++; $display("FAIL b2b_rd_req: got %0b %h %0b want 1 00000008 0", bus.m_valid, bus.m_addr, bus.m_we); end
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_0013;
        tick(); tick();
        n_cmp++; if ({stall, cpu_rdata} !== {1'b0, 32'h0000_0013}) begin n_fail++; $display("FAIL b2b_rd_done: got stall=%0b %h want stall=0 00000013", stall, cpu_rdata); end
        cpu_access = 1'b0; bus.m_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        cpu_access = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_4000; bus.m_ready = 1'b1; bus.m_rvalid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if ({bus_err, stall} !== 2'b01) begin n_fail++; $display("FAIL to_wait[%0d]: got err=%0b stall=%0b want err=0 stall=1", i, bus_err, stall); end
            tick();
        end
        n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b want 1", bus_err); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", cpu_rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_done: got %0b want 0", stall); end
        cpu_access = 1'b0;
        tick();
        cpu_access = 1'b1; cpu_adr = 32'h0000_4004;
        tick(); tick();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
        tick();
        n_cmp++; if ({bus_err, stall, cpu_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL to_sticky: got err=%0b stall=%0b %h want err=1 stall=0 cafef00d", bus_err, stall, cpu_rdata); end
        cpu_access = 1'b0; bus.m_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        cpu_access = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_6000; bus.m_ready = 1'b1; bus.m_rvalid = 1'b0;
        tick(); tick();
        n_cmp++; if ({bus.m_valid, stall} !== 2'b01) begin n_fail++; $display("FAIL rw_wait: got valid=%0b stall=%0b want valid=0 stall=1", bus.m_valid, stall); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({cpu_rdata, bus_err, bus.m_addr} !== 65'h0) begin n_fail++; $display("FAIL rw_async: got %h %0b %h want 0 0 0", cpu_rdata, bus_err, bus.m_addr); end
        cpu_access = 1'b0;
        tick();
        reset = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234_5678;
        tick(); tick();
        n_cmp++; if ({bus.m_valid, stall, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rw_after: got valid=%0b stall=%0b err=%0b want 000", bus.m_valid, stall, bus_err); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_rdata: got %h want 0", cpu_rdata); end
        bus.m_rvalid = 1'b0;
        cpu_access = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rw_idle_stall: got %0b want 1", stall); end
        cpu_access = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_backpressure();
        test_input_churn();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
